uart_word_rx: RTL

UART 8N1 receiver that assembles two received bytes into one 16-bit word for the instruction loader FSM. It sits between the board RX pin and the loader. It presents data_out/data_valid in the form the loader consumes: one word per single-cycle data_valid pulse. The first word of a transfer is the instruction count; the following words are instructions.

---
 rtl/uart_word_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_word_rx.sv
// UART receiver that pairs two bytes into one 16-bit word, {first, second}.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead of 8N1.
module uart_word_rx #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned TIMEOUT_BITS = 10
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        rx_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  // CLKS_PER_BIT must be at least 4 for the half-bit start sample to work.
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int          CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int          TMO_W        = $clog2(TMO_LIMIT + 1);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TMO_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       hi_q;
  logic             phase_q;
  logic             byte_ok_q;
  logic [15:0]      data_out_q;
  logic             data_valid_q;
  logic             frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q;
`endif

  logic rx_s;
  assign rx_s = sync_q[1];

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      clk_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      hi_q         <= '0;
      phase_q      <= 1'b0;
      byte_ok_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], rx_in};
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_ok_q    <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // A start bit beats a timeout expiring on the same cycle.
          if (!rx_s) begin
            state_q   <= S_START;
            clk_cnt_q <= '0;
            tmo_cnt_q <= '0;
          end else if (phase_q) begin
            if (tmo_cnt_q == TMO_END) begin
              phase_q   <= 1'b0;
              tmo_cnt_q <= '0;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
          end
        end

        S_START: begin
          if (clk_cnt_q == HALF_M1) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (clk_cnt_q == BIT_M1) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt_q == BIT_M1) begin
            clk_cnt_q <= '0;
            par_err_q <= (rx_s != ^shift_q);
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          // Back to IDLE mid stop bit so a back-to-back start edge is not missed.
          if (clk_cnt_q == BIT_M1) begin
            clk_cnt_q <= '0;
            state_q   <= S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (rx_s && !par_err_q) begin
`else
            if (rx_s) begin
`endif
              byte_ok_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              phase_q     <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // shift_q stays stable here: the next DATA sample is at least a bit period away.
      if (byte_ok_q) begin
        if (phase_q) begin
          data_out_q   <= {hi_q, shift_q};
          data_valid_q <= 1'b1;
          phase_q      <= 1'b0;
        end else begin
          hi_q    <= shift_q;
          phase_q <= 1'b1;
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE) || phase_q;

endmodule
